// File: rtl/counter_pkg.sv
// Shared constants and sizing helper for the counter library.
package counter_pkg;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  // Bits needed to hold 0..value-1, never less than one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned bits;
    bits = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) bits = i + 1;
    end
    return (bits == 0) ? 1 : bits;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled cycles by PRESCALE and emits a single-cycle Tick.
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Enable,
  input  logic Clear,
  output logic Tick
);

  localparam int unsigned PS_W = clog2(PRESCALE);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("tick_prescaler: PRESCALE must be at least 1");
  end

  logic [PS_W-1:0] ps;

  assign Tick = Enable & ~Clear & (ps == PS_LAST);

  // Clear (parallel load) discards any partial prescale count.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ps <= '0;
    end else if (Clear) begin
      ps <= '0;
    end else if (Enable) begin
      ps <= Tick ? '0 : ps + PS_W'(1);
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with parallel load, prescaled enable and
// wrap or saturate behaviour at the range ends.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH    = 8,
  parameter longint unsigned  MODULUS  = 256,
  parameter int unsigned      PRESCALE = 1,
  parameter int unsigned      MODE     = MODE_WRAP
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             Carry,
  output logic             AtMax,
  output logic             AtMin
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("mod_updown_counter: WIDTH must be in 1..32");
  end
  if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("mod_updown_counter: MODULUS must be in 2..2^WIDTH");
  end
  if (MODE != MODE_WRAP && MODE != MODE_SAT) begin : g_bad_mode
    $error("mod_updown_counter: MODE must be MODE_WRAP or MODE_SAT");
  end

  localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 1);

  logic             tick;
  logic [WIDTH-1:0] load_val;
  logic             at_bound;
  logic [WIDTH-1:0] q_next;
  logic             carry_next;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .Clock  (Clock),
    .Reset  (Reset),
    .Enable (Enable),
    .Clear  (Load),
    .Tick   (tick)
  );

  // Load beats tick; a boundary tick either wraps with Carry or holds.
  always_comb begin
    q_next     = Q;
    carry_next = 1'b0;
    load_val   = (D > Q_MAX) ? Q_MAX : D;
    at_bound   = Up ? (Q == Q_MAX) : (Q == '0);
    if (Load) begin
      q_next = load_val;
    end else if (tick) begin
      if (!at_bound) begin
        q_next = Up ? Q + WIDTH'(1) : Q - WIDTH'(1);
      end else if (MODE == MODE_WRAP) begin
        q_next     = Up ? '0 : Q_MAX;
        carry_next = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      Q     <= '0;
      Carry <= 1'b0;
    end else begin
      Q     <= q_next;
      Carry <= carry_next;
    end
  end

  assign AtMax = (Q == Q_MAX);
  assign AtMin = (Q == '0);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed-vector bench for mod_updown_counter across several configurations.
module tb_mod_updown_counter;
  import counter_pkg::*;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       up;
  logic       load;
  logic [3:0] d;

  logic [3:0] wrap_q, sat_q, ps3_q, ps4_q;
  logic [0:0] m2_q;
  logic       wrap_carry, sat_carry, ps3_carry, ps4_carry, m2_carry;
  logic       wrap_max, sat_max, ps3_max, ps4_max, m2_max;
  logic       wrap_min, sat_min, ps3_min, ps4_min, m2_min;

  int vectors;
  int miscompares;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .MODE(MODE_WRAP)) u_wrap (
    .Clock(clk), .Reset(reset), .Enable(enable), .Up(up), .Load(load), .D(d),
    .Q(wrap_q), .Carry(wrap_carry), .AtMax(wrap_max), .AtMin(wrap_min));

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .MODE(MODE_SAT)) u_sat (
    .Clock(clk), .Reset(reset), .Enable(enable), .Up(up), .Load(load), .D(d),
    .Q(sat_q), .Carry(sat_carry), .AtMax(sat_max), .AtMin(sat_min));

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3), .MODE(MODE_WRAP)) u_ps3 (
    .Clock(clk), .Reset(reset), .Enable(enable), .Up(up), .Load(load), .D(d),
    .Q(ps3_q), .Carry(ps3_carry), .AtMax(ps3_max), .AtMin(ps3_min));

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(4), .MODE(MODE_WRAP)) u_ps4 (
    .Clock(clk), .Reset(reset), .Enable(enable), .Up(up), .Load(load), .D(d),
    .Q(ps4_q), .Carry(ps4_carry), .AtMax(ps4_max), .AtMin(ps4_min));

  mod_updown_counter #(.WIDTH(1), .MODULUS(2), .PRESCALE(1), .MODE(MODE_WRAP)) u_m2 (
    .Clock(clk), .Reset(reset), .Enable(enable), .Up(up), .Load(load), .D(d[0:0]),
    .Q(m2_q), .Carry(m2_carry), .AtMax(m2_max), .AtMin(m2_min));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; load = 1'b0; up = 1'b1; d = 4'd0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1; enable = 1'b0; up = 1'b1; load = 1'b0; d = 4'd0;

    // Reset state of every configuration
    step();
    check("rst_wrap_q", 32'(wrap_q), 0);
    check("rst_wrap_carry", 32'(wrap_carry), 0);
    check("rst_wrap_atmin", 32'(wrap_min), 1);
    check("rst_wrap_atmax", 32'(wrap_max), 0);
    check("rst_sat_q", 32'(sat_q), 0);
    check("rst_ps3_q", 32'(ps3_q), 0);
    check("rst_ps4_q", 32'(ps4_q), 0);
    check("rst_m2_q", 32'(m2_q), 0);

    // Up count with wrap: 1..9 then 0 with Carry
    reset = 1'b0; enable = 1'b1; up = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      check("up_q", 32'(wrap_q), i % 10);
      check("up_carry", 32'(wrap_carry), (i == 10) ? 1 : 0);
      check("up_atmax", 32'(wrap_max), (i == 9) ? 1 : 0);
    end

    // Load clamp, then down count with wrap back to 9
    enable = 1'b0; load = 1'b1; d = 4'd15;
    step();
    check("clamp_q", 32'(wrap_q), 9);
    check("clamp_carry", 32'(wrap_carry), 0);
    load = 1'b0; enable = 1'b1; up = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      check("down_q", 32'(wrap_q), (i <= 9) ? 9 - i : 9);
      check("down_carry", 32'(wrap_carry), (i == 10) ? 1 : 0);
      check("down_atmin", 32'(wrap_min), (i == 9) ? 1 : 0);
    end
    enable = 1'b0; load = 1'b1; d = 4'd3;
    step();
    check("load3_q", 32'(wrap_q), 3);
    load = 1'b0;

    // Saturate at the top and bottom
    do_reset();
    load = 1'b1; d = 4'd8;
    step();
    check("sat_load_q", 32'(sat_q), 8);
    load = 1'b0; enable = 1'b1; up = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      check("sat_hold_q", 32'(sat_q), 9);
      check("sat_hold_carry", 32'(sat_carry), 0);
      check("sat_atmax", 32'(sat_max), 1);
    end
    up = 1'b0;
    step();
    check("sat_resume_q", 32'(sat_q), 8);
    load = 1'b1; d = 4'd0;
    step();
    load = 1'b0;
    step();
    check("sat_floor_q", 32'(sat_q), 0);
    check("sat_floor_carry", 32'(sat_carry), 0);

    // Prescale by 3: nine enabled cycles give three steps
    do_reset();
    enable = 1'b1; up = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step();
      check("ps3_q", 32'(ps3_q), i / 3);
    end
    begin
      logic [4:0] pattern;
      int         expq [5];
      pattern = 5'b10101;
      expq = '{3, 3, 3, 3, 4};
      for (int i = 0; i < 5; i++) begin
        enable = pattern[4 - i];
        step();
        check("ps3_gate_q", 32'(ps3_q), expq[i]);
      end
    end

    // Priority: Load beats a wrapping tick, Reset beats Load
    do_reset();
    load = 1'b1; d = 4'd9;
    step();
    check("pri_load9_q", 32'(wrap_q), 9);
    load = 1'b1; d = 4'd5; enable = 1'b1; up = 1'b1;
    step();
    check("pri_load_q", 32'(wrap_q), 5);
    check("pri_load_carry", 32'(wrap_carry), 0);
    reset = 1'b1; load = 1'b1; d = 4'd7;
    step();
    check("pri_reset_q", 32'(wrap_q), 0);
    reset = 1'b0; load = 1'b0; enable = 1'b0;

    // Reset mid-prescale discards the partial count
    do_reset();
    enable = 1'b1; up = 1'b1;
    step();
    step();
    check("ps4_pre_q", 32'(ps4_q), 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("ps4_after_q", 32'(ps4_q), 0);
    end
    step();
    check("ps4_step_q", 32'(ps4_q), 1);

    // Modulus 2: a wrap on every other up step, and down from 0 wraps
    do_reset();
    enable = 1'b1; up = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("m2_up_q", 32'(m2_q), i % 2);
      check("m2_up_carry", 32'(m2_carry), (i % 2 == 0) ? 1 : 0);
    end
    up = 1'b0;
    step();
    check("m2_down_q", 32'(m2_q), 1);
    check("m2_down_carry", 32'(m2_carry), 1);
    step();
    check("m2_down2_q", 32'(m2_q), 0);
    check("m2_down2_carry", 32'(m2_carry), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
